// File: rtl/signed_divider_if.sv
// Handshake and operand/result bundle for the sequential signed divider.
// Master issues start with operands; slave returns sign-magnitude results.
interface signed_divider_if;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic        quot_sign;
    logic [7:0]  remainder;
    logic        rem_sign;
    logic        dbz;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, quot_sign, remainder, rem_sign, dbz
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, quot_sign, remainder, rem_sign, dbz
    );
endinterface

// File: rtl/signed_divider.sv
// Sequential signed restoring divider: 16-bit dividend / 8-bit divisor,
// one quotient bit per clock, results in sign-magnitude form.
//
// state     | meaning
// ST_IDLE   | waiting for start, operands captured on accept
// ST_LOAD   | take magnitudes, clear partial remainder and counter
// ST_DIVIDE | 16 shift/compare/subtract steps
// ST_DONE   | register results (or divide-by-zero), pulse done
module signed_divider (
    input  logic             sys_clk,
    input  logic             rst,
    signed_divider_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DIVIDE,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        sd_q, sd_d;
    logic        sv_q, sv_d;
    logic [15:0] dvd_q, dvd_d;
    logic [7:0]  dvs_q, dvs_d;
    logic [15:0] a_q, a_d;
    logic [8:0]  p_q, p_d;
    logic [7:0]  m_q, m_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] quotient_q, quotient_d;
    logic        quot_sign_q, quot_sign_d;
    logic [7:0]  remainder_q, remainder_d;
    logic        rem_sign_q, rem_sign_d;
    logic        dbz_q, dbz_d;

    logic [8:0]  p_shift;
    logic [15:0] a_shift;
    logic [8:0]  p_diff;

    always_comb begin
        state_d     = state_q;
        sd_d        = sd_q;
        sv_d        = sv_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        a_d         = a_q;
        p_d         = p_q;
        m_d         = m_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        quot_sign_d = quot_sign_q;
        remainder_d = remainder_q;
        rem_sign_d  = rem_sign_q;
        dbz_d       = dbz_q;

        p_shift = {p_q[7:0], a_q[15]};
        a_shift = {a_q[14:0], 1'b0};
        p_diff  = p_shift - {1'b0, m_q};

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    dvd_d   = bus.dividend;
                    dvs_d   = bus.divisor;
                    sd_d    = bus.dividend[15];
                    sv_d    = bus.divisor[7];
                    busy_d  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // -32768 and -128 negate to themselves, which is the correct unsigned magnitude
                a_d     = sd_q ? (~dvd_q + 16'd1) : dvd_q;
                m_d     = sv_q ? (~dvs_q + 8'd1) : dvs_q;
                p_d     = 9'd0;
                cnt_d   = 4'd0;
                state_d = (dvs_q == 8'd0) ? ST_DONE : ST_DIVIDE;
            end
            ST_DIVIDE: begin
                if (p_shift >= {1'b0, m_q}) begin
                    p_d = p_diff;
                    a_d = {a_shift[15:1], 1'b1};
                end else begin
                    p_d = p_shift;
                    a_d = a_shift;
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (m_q == 8'd0) begin
                    quotient_d  = 16'd0;
                    quot_sign_d = 1'b0;
                    remainder_d = 8'd0;
                    rem_sign_d  = 1'b0;
                    dbz_d       = 1'b1;
                end else begin
                    quotient_d  = a_q;
                    quot_sign_d = (a_q != 16'd0) && (sd_q ^ sv_q);
                    remainder_d = p_q[7:0];
                    rem_sign_d  = (p_q[7:0] != 8'd0) && sd_q;
                    dbz_d       = 1'b0;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sd_q        <= 1'b0;
            sv_q        <= 1'b0;
            dvd_q       <= 16'd0;
            dvs_q       <= 8'd0;
            a_q         <= 16'd0;
            p_q         <= 9'd0;
            m_q         <= 8'd0;
            cnt_q       <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= 16'd0;
            quot_sign_q <= 1'b0;
            remainder_q <= 8'd0;
            rem_sign_q  <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sd_q        <= sd_d;
            sv_q        <= sv_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            a_q         <= a_d;
            p_q         <= p_d;
            m_q         <= m_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            quot_sign_q <= quot_sign_d;
            remainder_q <= remainder_d;
            rem_sign_q  <= rem_sign_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quotient_q;
    assign bus.quot_sign = quot_sign_q;
    assign bus.remainder = remainder_q;
    assign bus.rem_sign  = rem_sign_q;
    assign bus.dbz       = dbz_q;

endmodule

// File: doc/signed_divider.md
# signed_divider

Sequential signed restoring divider, the inverse operation of the team's shift-add signed multiplier. It accepts a 16-bit two's-complement dividend and an 8-bit two's-complement divisor on a start pulse. It produces quotient and remainder in sign-magnitude form, one quotient bit per clock. Its sign/magnitude outputs feed the existing bin_to_bcd / seven-segment display path unchanged, with the sign handled as a separate digit exactly as the multiplier's result is.

## Interface
- No parameters; widths fixed at 16-bit dividend and 8-bit divisor.
- sys_clk: input, 1 bit. The single clock; all state changes on its rising edge.
- rst: input, 1 bit. Synchronous, active-high reset.
- start: input, 1 bit. Single-cycle request (debounced push-button pulse); sampled only in IDLE.
- dividend: input, 16 bits. Two's-complement dividend; captured on the edge that accepts start.
- divisor: input, 8 bits. Two's-complement divisor; captured on the same edge.
- busy: output, 1 bit. High from the accept edge until the done edge.
- done: output, 1 bit. One-cycle pulse when results become valid.
- quotient: output, 16 bits. Quotient magnitude.
- quot_sign: output, 1 bit. 1 = negative quotient.
- remainder: output, 8 bits. Remainder magnitude.
- rem_sign: output, 1 bit. 1 = negative remainder.
- dbz: output, 1 bit. Divide-by-zero flag for the last operation.

## Operation
- FSM states and transitions:
  - IDLE: goes to LOAD when start=1.
  - LOAD: goes to DONE if the captured divisor is 0, otherwise to DIVIDE.
  - DIVIDE: held for exactly 16 cycles (4-bit counter 0..15), then goes to DONE.
  - DONE: always returns to IDLE.
- IDLE:
  - Operands are captured when start is accepted.
  - Dividend sign sd = dividend[15]; divisor sign sv = divisor[7].
- LOAD:
  - Computes |dividend| as a 16-bit unsigned value (-32768 gives 0x8000).
  - Computes |divisor| as an 8-bit unsigned value (-128 gives 0x80).
  - Clears the 9-bit partial remainder P and the counter.
- DIVIDE, each cycle:
  - P = {P[7:0], A[15]} and A = A << 1.
  - If P >= |divisor|, then P = P - |divisor| and A[0] = 1; otherwise A[0] = 0.
  - After 16 cycles A holds the quotient magnitude and P[7:0] holds the remainder magnitude (at most 127).
- DONE, registered outputs:
  - quotient = A; remainder = P[7:0].
  - quot_sign = sd ^ sv when quotient != 0, else 0.
  - rem_sign = sd when remainder != 0, else 0.
  - dbz = 0; done = 1 for this single cycle; busy = 0.
  - Division truncates toward zero.
- Divide-by-zero path (LOAD to DONE directly): quotient = 0, remainder = 0, both signs = 0, dbz = 1, done pulses.
- Results and dbz hold their values until the next DONE or rst.
- start is ignored outside IDLE, including during the DONE cycle and while busy.
- rst in any state:
  - Returns the FSM to IDLE.
  - Clears all outputs to 0: busy, done, quotient, quot_sign, remainder, rem_sign, dbz.
  - An in-flight operation is discarded and produces no done.

## Timing
- Reset values: every output is 0; FSM is in IDLE.
- Normal latency:
  - Start accepted at edge E0; busy=1 after E0.
  - LOAD at E1; DIVIDE at E2 through E17; DONE at E18.
  - done=1 and results valid in the cycle after E18, i.e. 18 cycles after accept; busy falls at E18.
- Divide-by-zero latency: done and dbz valid after E2 (2 cycles).
- The next start is accepted no earlier than the edge following E18 (or E2 for divide-by-zero).
- Inputs may change freely after E0; only the captured copies are used.

## Test plan
- 0xFF71 (-143) / 0x0B (11):
  - quotient = 13, quot_sign = 1, remainder = 0, rem_sign = 0.
  - done exactly 18 cycles after start.
- 100 / 0xF9 (-7): quotient = 14, quot_sign = 1, remainder = 2, rem_sign = 0.
- 0xFF9C (-100) / 7: quotient = 14, quot_sign = 1, remainder = 2, rem_sign = 1.
- Extremes:
  - 0x8000 / 0x01 gives quotient = 0x8000, quot_sign = 1.
  - 0x8000 / 0x80 gives quotient = 256, quot_sign = 0, remainder = 0.
  - 5 / 0xF9 (-7) gives quotient = 0, quot_sign = 0, remainder = 5.
- 50 / 0:
  - dbz = 1, quotient = 0, remainder = 0, done 2 cycles after start.
  - A following 50 / 5 gives dbz = 0, quotient = 10.
- Control robustness:
  - A start pulse at cycle 5 of an active divide is ignored; the original result is unchanged and there is a single done.
  - rst at cycle 8 of a divide clears all outputs, and no done appears within 30 cycles.
  - A fresh start then completes normally.
